sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Shares one synchronous single-port SRAM between the instruction-fetch requester and the data (load/store) requester. It sits between the fetch/memory stages and the memory macro. Each cycle it grants at most one request, drives the SRAM enable/write/address/data lines, and routes the one-cycle-later read data back to the granted requester. Data requests have priority, with a starvation limit that protects fetch. A fetch-cancel input drops in-flight fetch responses on exception/ertn/branch redirect.

## Interface
Parameters:
- STARVE_LIMIT, default 4: maximum consecutive data grants while a fetch request waits; legal range 1..15.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- inst_req  in  1  fetch read request, held until inst_addr_ok.
- inst_addr  in  32  fetch address.
- inst_cancel  in  1  drop the in-flight fetch response and block a fetch grant this cycle.
- inst_addr_ok  out  1  fetch request granted this cycle.
- inst_data_ok  out  1  fetch read data valid.
- inst_rdata  out  32  fetch read data.
- data_req  in  1  data request, held until data_addr_ok.
- data_we  in  4  byte write strobes; 0 means read.
- data_addr  in  32  data address.
- data_wdata  in  32  store data.
- data_addr_ok  out  1  data request granted this cycle.
- data_data_ok  out  1  data response valid (read data or write ack).
- data_rdata  out  32  load data; 0 on write ack.
- sram_en  out  1  SRAM access enable.
- sram_we  out  4  SRAM byte write enables.
- sram_addr  out  32  SRAM address.
- sram_wdata  out  32  SRAM write data.
- sram_rdata  in  32  SRAM read data, valid the cycle after an enabled read.

## Operation
- Grant logic is combinational on the current-cycle requests and registered state. At most one of inst_addr_ok/data_addr_ok is high in a cycle.
- Fetch is eligible when inst_req=1 and inst_cancel=0.
- Priority:
  - data wins when both are eligible, unless streak_cnt == STARVE_LIMIT, in which case fetch wins.
  - A lone eligible requester always wins.
- streak_cnt (4 bits):
  - +1 on each data grant while fetch is eligible.
  - cleared on any fetch grant, and in any cycle fetch is not eligible.
  - saturates at STARVE_LIMIT.
- On grant: sram_en=1; sram_addr and sram_we/sram_wdata come from the winner. A fetch grant drives sram_we=0 and sram_wdata=0.
- No grant: sram_en=0, sram_we=0, sram_addr=0, sram_wdata=0.
- Response tracking registers, set on the grant edge:
  - rsp_valid (1)
  - rsp_owner (0=inst, 1=data)
  - rsp_write (1)
- Response cycle, the cycle after a grant:
  - owner inst, not killed: inst_data_ok=1, inst_rdata=sram_rdata.
  - owner data read: data_data_ok=1, data_rdata=sram_rdata.
  - owner data write: data_data_ok=1, data_rdata=0.
- Cancel: inst_cancel=1 while a fetch response is outstanding (rsp_valid & owner inst) forces inst_data_ok=0 in that same cycle. A cancel in the grant cycle blocks the grant itself.
- Data responses are never cancelled.
- Idle rdata outputs are 0. The arbiter does not check alignment; that belongs to the requesting stages.

## Timing
- Reset (async assert): rsp_valid=0, rsp_owner=0, rsp_write=0, streak_cnt=0. While reset=1, all outputs are 0, including the addr_ok outputs and sram_en.
- Latency: grant in cycle N, response in cycle N+1. Back-to-back grants every cycle; throughput is one access per cycle.
- Requesters must hold req/addr/we/wdata stable until addr_ok. The arbiter never accepts a request without addr_ok.
- A grant in cycle N+1 may overlap the response of cycle N, with no bubble.
- Simultaneous inst_cancel and a fetch response in the same cycle: the response is dropped and no fetch grant occurs. A data grant in that cycle proceeds normally.
- Reset deasserted mid-operation: the first post-reset cycle behaves as idle, with no stale responses.

## Test plan
- Reset: assert reset asynchronously mid-cycle with both reqs high -> all outputs 0 immediately. After release, first grant goes to data; sram_en=1, sram_addr=data_addr.
- Fetch alone: inst_req=1, inst_addr=0x1c000000 for 3 cycles; SRAM returns 0xA, 0xB, 0xC -> inst_addr_ok every cycle, inst_data_ok one cycle later each, inst_rdata 0xA, 0xB, 0xC.
- Starvation, STARVE_LIMIT=4: both requesters continuously requesting -> grant pattern D,D,D,D,I,D,D,D,D,I; streak_cnt returns to 0 after each I.
- Store ack: data_we=4'b0011, addr 0x100, wdata 0x12345678 -> sram_we=4'b0011, sram_wdata=0x12345678. Next cycle data_data_ok=1, data_rdata=0.
- Cancel: fetch granted at 0x1c000010 in cycle N, inst_cancel=1 in N+1 -> inst_data_ok=0 in N+1 and no fetch grant in N+1. A pending data_req is granted in N+1.
- Mixed overlap: data load granted in N, fetch granted in N+1 -> data_data_ok in N+1, inst_data_ok in N+2, no cross-routing of rdata.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Arbitrates one single-port synchronous SRAM between instruction fetch and data access.
// Data normally wins, but a streak counter guarantees fetch a slot after STARVE_LIMIT data grants.
module sram_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   input  logic        inst_cancel,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic [3:0]  data_we,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        sram_en,
   output logic [3:0]  sram_we,
   output logic [31:0] sram_addr,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0] streak_cnt;
   logic [3:0] streak_next;
   logic       rsp_valid;
   logic       rsp_owner;
   logic       rsp_write;
   logic       inst_elig;
   logic       data_elig;
   logic       grant_inst;
   logic       grant_data;

   // Reset gating keeps every output low while reset is held, including combinational grants.
   always_comb begin
      inst_elig  = inst_req & ~inst_cancel & ~reset;
      data_elig  = data_req & ~reset;
      grant_inst = inst_elig & (~data_elig | (streak_cnt == LIMIT));
      grant_data = data_elig & ~grant_inst;
   end

   always_comb begin
      streak_next = streak_cnt;
      if (grant_inst || !inst_elig) begin
         streak_next = 4'd0;
      end else if (grant_data) begin
         streak_next = (streak_cnt >= LIMIT) ? LIMIT : streak_cnt + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         streak_cnt <= 4'd0;
         rsp_valid  <= 1'b0;
         rsp_owner  <= 1'b0;
         rsp_write  <= 1'b0;
      end else begin
         streak_cnt <= streak_next;
         rsp_valid  <= grant_inst | grant_data;
         rsp_owner  <= grant_data;
         rsp_write  <= grant_data & (|data_we);
      end
   end

   always_comb begin
      sram_en    = 1'b0;
      sram_we    = 4'd0;
      sram_addr  = 32'd0;
      sram_wdata = 32'd0;
      if (grant_inst) begin
         sram_en   = 1'b1;
         sram_addr = inst_addr;
      end else if (grant_data) begin
         sram_en    = 1'b1;
         sram_we    = data_we;
         sram_addr  = data_addr;
         sram_wdata = data_wdata;
      end
   end

   // A fetch response is squashed by a cancel arriving in its response cycle.
   always_comb begin
      inst_addr_ok = grant_inst;
      data_addr_ok = grant_data;
      inst_data_ok = rsp_valid & ~rsp_owner & ~inst_cancel;
      data_data_ok = rsp_valid & rsp_owner;
      inst_rdata   = inst_data_ok ? sram_rdata : 32'd0;
      data_rdata   = (data_data_ok && !rsp_write) ? sram_rdata : 32'd0;
   end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: grant checks per step plus a one-deep response scoreboard.
module tb_sram_port_arbiter;

   logic        clk;
   logic        reset;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_cancel;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req;
   logic [3:0]  data_we;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;
   logic        sram_en;
   logic [3:0]  sram_we;
   logic [31:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;

   typedef struct packed {
      logic valid;
      logic owner;
      logic write;
   } rsp_t;

   rsp_t sb[$];
   int   n_asserts = 0;
   int   n_fails   = 0;

   localparam int G_NONE = 0;
   localparam int G_INST = 1;
   localparam int G_DATA = 2;

   sram_port_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk(clk), .reset(reset),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
      .sram_rdata(sram_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_asserts++;
      assert (got === want) else begin
         n_fails++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, got, want);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " inst_addr_ok"}, 32'(inst_addr_ok), 32'd0);
      checkOutput({tag, " data_addr_ok"}, 32'(data_addr_ok), 32'd0);
      checkOutput({tag, " inst_data_ok"}, 32'(inst_data_ok), 32'd0);
      checkOutput({tag, " data_data_ok"}, 32'(data_data_ok), 32'd0);
      checkOutput({tag, " inst_rdata"}, inst_rdata, 32'd0);
      checkOutput({tag, " data_rdata"}, data_rdata, 32'd0);
      checkOutput({tag, " sram_en"}, 32'(sram_en), 32'd0);
      checkOutput({tag, " sram_we"}, 32'(sram_we), 32'd0);
      checkOutput({tag, " sram_addr"}, sram_addr, 32'd0);
      checkOutput({tag, " sram_wdata"}, sram_wdata, 32'd0);
   endtask

   // One clock step: called at a falling edge, drives inputs, checks, then moves to the next falling edge.
   task automatic applyStimulus(input string tag, input logic ir, input logic [31:0] ia, input logic ic,
                                input logic dr, input logic [3:0] dwe, input logic [31:0] da,
                                input logic [31:0] dwd, input logic [31:0] rd, input int exp_grant);
      rsp_t cur;
      rsp_t nxt;
      inst_req    = ir;
      inst_addr   = ia;
      inst_cancel = ic;
      data_req    = dr;
      data_we     = dwe;
      data_addr   = da;
      data_wdata  = dwd;
      sram_rdata  = rd;
      #1;
      checkOutput({tag, " inst_addr_ok"}, 32'(inst_addr_ok), 32'(exp_grant == G_INST));
      checkOutput({tag, " data_addr_ok"}, 32'(data_addr_ok), 32'(exp_grant == G_DATA));
      checkOutput({tag, " sram_en"}, 32'(sram_en), 32'(exp_grant != G_NONE));
      checkOutput({tag, " sram_addr"}, sram_addr,
                  (exp_grant == G_INST) ? ia : (exp_grant == G_DATA) ? da : 32'd0);
      checkOutput({tag, " sram_we"}, 32'(sram_we), (exp_grant == G_DATA) ? 32'(dwe) : 32'd0);
      checkOutput({tag, " sram_wdata"}, sram_wdata, (exp_grant == G_DATA) ? dwd : 32'd0);
      cur = '0;
      if (sb.size() > 0) cur = sb.pop_front();
      checkOutput({tag, " inst_data_ok"}, 32'(inst_data_ok), 32'(cur.valid && !cur.owner && !ic));
      checkOutput({tag, " inst_rdata"}, inst_rdata, (cur.valid && !cur.owner && !ic) ? rd : 32'd0);
      checkOutput({tag, " data_data_ok"}, 32'(data_data_ok), 32'(cur.valid && cur.owner));
      checkOutput({tag, " data_rdata"}, data_rdata, (cur.valid && cur.owner && !cur.write) ? rd : 32'd0);
      nxt.valid = (exp_grant != G_NONE);
      nxt.owner = (exp_grant == G_DATA);
      nxt.write = (exp_grant == G_DATA) && (|dwe);
      sb.push_back(nxt);
      @(negedge clk);
   endtask

   task automatic idleStep(input string tag, input logic [31:0] rd);
      applyStimulus(tag, 1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, rd, G_NONE);
   endtask

   initial begin
      int pattern [10];
      reset       = 1'b1;
      inst_req    = 1'b0;
      inst_addr   = 32'd0;
      inst_cancel = 1'b0;
      data_req    = 1'b0;
      data_we     = 4'd0;
      data_addr   = 32'd0;
      data_wdata  = 32'd0;
      sram_rdata  = 32'h5555_5555;
      repeat (2) @(negedge clk);
      checkAllZero("initial reset");
      reset = 1'b0;

      $display("[TB] fetch alone");
      applyStimulus("fetch0", 1'b1, 32'h1c00_0000, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 32'h0, G_INST);
      applyStimulus("fetch1", 1'b1, 32'h1c00_0000, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 32'hA, G_INST);
      applyStimulus("fetch2", 1'b1, 32'h1c00_0000, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 32'hB, G_INST);
      idleStep("fetch3", 32'hC);

      $display("[TB] starvation limit 4");
      pattern = '{G_DATA, G_DATA, G_DATA, G_DATA, G_INST, G_DATA, G_DATA, G_DATA, G_DATA, G_INST};
      for (int i = 0; i < 10; i++) begin
         applyStimulus($sformatf("starve%0d", i), 1'b1, 32'h1c00_0100 + 32'(i * 4), 1'b0,
                       1'b1, 4'd0, 32'h0000_2000 + 32'(i * 4), 32'd0, 32'h7000_0000 + 32'(i), pattern[i]);
      end
      idleStep("starve_tail", 32'h7000_00FF);

      $display("[TB] store ack");
      applyStimulus("store", 1'b0, 32'd0, 1'b0, 1'b1, 4'b0011, 32'h100, 32'h1234_5678, 32'h0, G_DATA);
      idleStep("store_ack", 32'hDEAD_BEEF);

      $display("[TB] fetch cancel");
      applyStimulus("cancel_grant", 1'b1, 32'h1c00_0010, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 32'h0, G_INST);
      applyStimulus("cancel_rsp", 1'b1, 32'h1c00_0014, 1'b1, 1'b1, 4'd0, 32'h300, 32'd0, 32'hCAFE_0001, G_DATA);
      idleStep("cancel_tail", 32'hCAFE_0002);

      $display("[TB] mixed overlap");
      applyStimulus("mix_load", 1'b0, 32'd0, 1'b0, 1'b1, 4'd0, 32'h400, 32'd0, 32'h0, G_DATA);
      applyStimulus("mix_fetch", 1'b1, 32'h1c00_0020, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 32'h1111_1111, G_INST);
      idleStep("mix_tail", 32'h2222_2222);

      $display("[TB] asynchronous reset mid-cycle");
      applyStimulus("pre_reset", 1'b1, 32'h1c00_0030, 1'b0, 1'b1, 4'd0, 32'h500, 32'd0, 32'h0, G_DATA);
      inst_req   = 1'b1;
      data_req   = 1'b1;
      data_addr  = 32'h600;
      sram_rdata = 32'h3333_3333;
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      checkAllZero("mid reset");
      @(negedge clk);
      reset = 1'b0;
      sb.delete();
      applyStimulus("post_reset", 1'b1, 32'h1c00_0040, 1'b0, 1'b1, 4'd0, 32'h600, 32'd0, 32'h4444_4444, G_DATA);
      idleStep("post_reset_tail", 32'h5555_0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

endmodule
